line_buffer: RTL

LINE_BUFFER -- requirements
Module: line_buffer

---
 rtl/line_buffer_pkg.sv | 13 +
 rtl/line_ram.sv | 49 ++++
 rtl/line_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/line_buffer_pkg.sv
// Shared constants for the line buffer: default geometry and address-width helper.
package line_buffer_pkg;

  localparam int unsigned DefImageWidth = 640;
  localparam int unsigned DefPixelWidth = 1;
  localparam int unsigned DefNumLines   = 3;

  // Address bits needed to index one image line.
  function automatic int unsigned calcAddrWidth(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line memory: Depth x Width storage, one read port with a registered,
// resettable read-data register and one write port. A read and a write to the
// same address in the same cycle returns the pre-write contents.
//
// Ports:
//   Clock      rising-edge clock
//   nReset     async active-low reset (clears ReadData only, never the array)
//   ReadEn     capture Storage[ReadAddr] into ReadData on the next edge
//   ReadAddr   read address
//   ReadData   registered read data
//   WriteEn    write WriteData to Storage[WriteAddr] on the next edge
//   WriteAddr  write address
//   WriteData  write data
module line_ram
  import line_buffer_pkg::*;
#(
  parameter  int unsigned Width     = DefPixelWidth,
  parameter  int unsigned Depth     = DefImageWidth,
  localparam int unsigned AddrWidth = calcAddrWidth(Depth)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 ReadEn,
  input  logic [AddrWidth-1:0] ReadAddr,
  output logic [Width-1:0]     ReadData,
  input  logic                 WriteEn,
  input  logic [AddrWidth-1:0] WriteAddr,
  input  logic [Width-1:0]     WriteData
);

  logic [Width-1:0] storage [Depth];

  // Array write; contents are deliberately not reset.
  always_ff @(posedge Clock) begin
    if (WriteEn) begin
      storage[WriteAddr] <= WriteData;
    end
  end

  // Registered read; holds when not enabled.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ReadData <= '0;
    end else if (ReadEn) begin
      ReadData <= storage[ReadAddr];
    end
  end

endmodule

// File: rtl/line_buffer.sv
// Vertical sliding-window line buffer. Accepts one raster-order pixel per
// cycle and presents, one cycle later, the column of NumLines pixels ending at
// that pixel (slot 0 = current line, slot k = k lines above).
//
// Optional feature: define LINE_BUFFER_BORDER_ZERO_EN to force slot k to zero
// while fewer than k lines of the current frame have been seen.
//
// Ports:
//   Clock       rising-edge clock
//   nReset      async active-low reset
//   FrameStart  restart column/row-fill tracking (pixel in same cycle is col 0)
//   ValidIn     DataIn qualifier
//   DataIn      input pixel
//   ValidOut    Window/Column/WindowFull valid
//   Window      NumLines*PixelWidth vertical pixel column
//   Column      column index of Window
//   WindowFull  all slots belong to the current frame
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter  int unsigned ImageWidth = DefImageWidth,
  parameter  int unsigned PixelWidth = DefPixelWidth,
  parameter  int unsigned NumLines   = DefNumLines,
  localparam int unsigned AddrWidth  = calcAddrWidth(ImageWidth)
) (
  input  logic                           Clock,
  input  logic                           nReset,
  input  logic                           FrameStart,
  input  logic                           ValidIn,
  input  logic [PixelWidth-1:0]          DataIn,
  output logic                           ValidOut,
  output logic [NumLines*PixelWidth-1:0] Window,
  output logic [AddrWidth-1:0]           Column,
  output logic                           WindowFull
);

  localparam int unsigned NumMems  = NumLines - 1;
  localparam int unsigned RowWidth = $clog2(NumLines);
  localparam logic [AddrWidth-1:0] LastCol = AddrWidth'(ImageWidth - 1);
  localparam logic [RowWidth-1:0]  LastRow = RowWidth'(NumLines - 1);

  logic [AddrWidth-1:0]  colCnt, colNext, curCol;
  logic [RowWidth-1:0]   rowCnt, rowNext, curRow;
  logic                  wrEn;
  logic [AddrWidth-1:0]  wrAddr;
  logic [PixelWidth-1:0] wrPix;
  logic [PixelWidth-1:0] pixReg;
  logic [PixelWidth-1:0] readData [NumMems];

  // Position of the pixel being accepted; FrameStart makes it column 0, row 0.
  always_comb begin
    curCol = colCnt;
    curRow = rowCnt;
    if (FrameStart) begin
      curCol = '0;
      curRow = '0;
    end
  end

  // Column / row-fill advance: wrap column, saturate row-fill at NumLines-1.
  always_comb begin
    colNext = curCol;
    rowNext = curRow;
    if (!ValidIn) begin
      colNext = FrameStart ? '0 : colCnt;
      rowNext = FrameStart ? '0 : rowCnt;
    end else if (curCol == LastCol) begin
      colNext = '0;
      rowNext = (curRow == LastRow) ? curRow : curRow + RowWidth'(1);
    end else begin
      colNext = curCol + AddrWidth'(1);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      colCnt <= '0;
      rowCnt <= '0;
    end else begin
      colCnt <= colNext;
      rowCnt <= rowNext;
    end
  end

  // Pending cascade write, issued the cycle after acceptance.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrPix  <= '0;
    end else begin
      wrEn <= ValidIn;
      if (ValidIn) begin
        wrAddr <= curCol;
        wrPix  <= DataIn;
      end
    end
  end

  // Output side-band registers; everything but ValidOut holds when idle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ValidOut   <= 1'b0;
      pixReg     <= '0;
      Column     <= '0;
      WindowFull <= 1'b0;
    end else begin
      ValidOut <= ValidIn;
      if (ValidIn) begin
        pixReg     <= DataIn;
        Column     <= curCol;
        WindowFull <= (curRow == LastRow);
      end
    end
  end

  // Cascade: memory 0 takes the new pixel, memory k takes memory k-1's read.
  for (genvar k = 0; k < NumMems; k++) begin : gMem
    logic [PixelWidth-1:0] wrData;
    if (k == 0) begin : gHead
      assign wrData = wrPix;
    end else begin : gTail
      assign wrData = readData[k-1];
    end
    line_ram #(
      .Width (PixelWidth),
      .Depth (ImageWidth)
    ) uRam (
      .Clock     (Clock),
      .nReset    (nReset),
      .ReadEn    (ValidIn),
      .ReadAddr  (curCol),
      .ReadData  (readData[k]),
      .WriteEn   (wrEn),
      .WriteAddr (wrAddr),
      .WriteData (wrData)
    );
  end

  assign Window[PixelWidth-1:0] = pixReg;

`ifdef LINE_BUFFER_BORDER_ZERO_EN
  logic [NumLines-1:1] keepNext, keepReg;

  // Slot k is meaningful only once k lines of this frame precede the pixel.
  always_comb begin
    keepNext = '0;
    for (int k = 1; k < NumLines; k++) begin
      keepNext[k] = (int'(curRow) >= k);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      keepReg <= '0;
    end else if (ValidIn) begin
      keepReg <= keepNext;
    end
  end

  for (genvar k = 1; k < NumLines; k++) begin : gSlot
    assign Window[k*PixelWidth +: PixelWidth] = keepReg[k] ? readData[k-1] : '0;
  end
`else
  for (genvar k = 1; k < NumLines; k++) begin : gSlot
    assign Window[k*PixelWidth +: PixelWidth] = readData[k-1];
  end
`endif

endmodule
